serial_slave_port: RTL

- Responder end of the serial system bus: deserializes the address, mode and write data that a master port shifts onto the bus.
- Performs the single-word access on a local slave memory (BRAM-style, registered read).
- For reads, serializes the read word back to the master with a per-bit valid strobe.
- Sits between the bus mux/address decoder and one slave memory; one instance per slave device.

---
 rtl/serial_slave_port.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_slave_port.sv
// Responder end of the serial system bus: deserializes address/mode/write data,
// performs one access on a registered-read slave memory, and serializes read data back.
module serial_slave_port #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // The counter also times RWAIT, so it must be able to reach READ_LATENCY.
   localparam int MAXW0 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int MAXW  = (MAXW0 > READ_LATENCY + 1) ? MAXW0 : READ_LATENCY + 1;
   localparam int CW    = $clog2(MAXW) + 1;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RWAIT, RSEND} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rsh_q, rsh_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsh_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rsh_q   <= rsh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rsh_d   = rsh_q;
      case (state_q)
         IDLE: begin
            if (mvalid) begin
               // Shift in at the MSB so bit i lands at position i after the last bit.
               addr_d = addr_q >> 1;
               addr_d[ADDR_WIDTH-1] = swdata;
               mode_d = smode;
               if (ADDR_WIDTH == 1) begin
                  cnt_d   = '0;
                  state_d = smode ? WDATA : RWAIT;
               end else begin
                  cnt_d   = CW'(1);
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (mvalid) begin
               addr_d = addr_q >> 1;
               addr_d[ADDR_WIDTH-1] = swdata;
               if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                  cnt_d   = '0;
                  state_d = mode_q ? WDATA : RWAIT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WDATA: begin
            if (mvalid) begin
               wdata_d = wdata_q >> 1;
               wdata_d[DATA_WIDTH-1] = swdata;
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  cnt_d   = '0;
                  state_d = WRITE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WRITE: begin
            // Strobe cycle, then one settle cycle before sready returns.
            if (cnt_q == '0) begin
               cnt_d = CW'(1);
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         RWAIT: begin
            if (cnt_q == CW'(READ_LATENCY)) begin
               rsh_d   = mem_rdata;
               cnt_d   = '0;
               state_d = RSEND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RSEND: begin
            rsh_d = rsh_q >> 1;
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign sready    = (state_q == IDLE);
   assign mem_wen   = (state_q == WRITE) && (cnt_q == '0);
   assign svalid    = (state_q == RSEND);
   assign srdata    = svalid & rsh_q[0];
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
